// File: rtl/cipher_stream_loader_pkg.sv
// Shared types and helpers for the AES-128 word-stream loader and its cipher core.
// State bytes are indexed [column][row]; word k carries column k, row 0 in bits [31:24].
package cipher_stream_loader_pkg;

  typedef logic [31:0]           word_t;
  typedef logic [3:0][3:0][7:0]  state_t;

  typedef enum logic [1:0] {COLLECT, SETTLE, EMIT} fsm_e;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  function automatic word_t col_to_word(input state_t s, input logic [1:0] k);
    return {s[k][0], s[k][1], s[k][2], s[k][3]};
  endfunction

  function automatic state_t word_to_col(input state_t s, input logic [1:0] k, input word_t w);
    state_t o;
    o       = s;
    o[k][0] = w[31:24];
    o[k][1] = w[23:16];
    o[k][2] = w[15:8];
    o[k][3] = w[7:0];
    return o;
  endfunction

endpackage

// File: rtl/cipher_stream_loader_if.sv
// Word-stream bundle between a producer/consumer (master) and the loader (slave).
interface cipher_stream_loader_if;
  import cipher_stream_loader_pkg::*;

  logic  key_valid;
  logic  key_ready;
  word_t key_word;
  logic  in_valid;
  logic  in_ready;
  word_t in_word;
  logic  out_valid;
  logic  out_ready;
  word_t out_word;
  logic  key_loaded;
  logic  busy;

  modport master (
    output key_valid, key_word, in_valid, in_word, out_ready,
    input  key_ready, in_ready, out_valid, out_word, key_loaded, busy
  );

  modport slave (
    input  key_valid, key_word, in_valid, in_word, out_ready,
    output key_ready, in_ready, out_valid, out_word, key_loaded, busy
  );

endinterface

// File: rtl/cipher_stream_loader_cipher.sv
// Purely combinational AES-128 encryption: key schedule and ten rounds unrolled.
// The loader treats this as a multicycle path and only samples data_o after settling.
module cipher
  import cipher_stream_loader_pkg::*;
(
  input  state_t key_i,
  input  state_t data_i,
  output state_t data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic state_t sub_shift(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = sbox(s[2'(c + r)][r]);
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++) begin
      o[c][0] = xtime(s[c][0]) ^ xtime(s[c][1]) ^ s[c][1] ^ s[c][2] ^ s[c][3];
      o[c][1] = s[c][0] ^ xtime(s[c][1]) ^ xtime(s[c][2]) ^ s[c][2] ^ s[c][3];
      o[c][2] = s[c][0] ^ s[c][1] ^ xtime(s[c][2]) ^ xtime(s[c][3]) ^ s[c][3];
      o[c][3] = xtime(s[c][0]) ^ s[c][0] ^ s[c][1] ^ s[c][2] ^ xtime(s[c][3]);
    end
    return o;
  endfunction

  function automatic state_t next_key(input state_t k, input logic [7:0] rc);
    state_t o;
    o[0][0] = k[0][0] ^ sbox(k[3][1]) ^ rc;
    o[0][1] = k[0][1] ^ sbox(k[3][2]);
    o[0][2] = k[0][2] ^ sbox(k[3][3]);
    o[0][3] = k[0][3] ^ sbox(k[3][0]);
    for (int c = 1; c < 4; c++) o[c] = k[c] ^ o[c-1];
    return o;
  endfunction

  function automatic state_t encrypt(input state_t key, input state_t pt);
    state_t     rk;
    state_t     st;
    logic [7:0] rc;
    rk = key;
    st = pt ^ key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, rc);
      rc = xtime(rc);
      st = sub_shift(st);
      if (r < 10) st = mix_columns(st);
      st = st ^ rk;
    end
    return st;
  endfunction

  assign data_o = encrypt(key_i, data_i);

endmodule

// File: rtl/cipher_stream_loader.sv
// Collects key/plaintext words, lets the combinational cipher settle, then streams
// the ciphertext out; one block in flight, key and data frozen outside COLLECT.
module cipher_stream_loader
  import cipher_stream_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input logic                  clk,
  input logic                  rst,
  cipher_stream_loader_if.slave bus
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
                              ((SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_EFF - 1);

  fsm_e       state_q;
  state_t     key_q;
  state_t     data_q;
  state_t     out_q;
  state_t     cipher_out;
  logic [1:0] key_cnt_q;
  logic [1:0] data_cnt_q;
  logic [1:0] emit_cnt_q;
  logic [3:0] settle_cnt_q;
  logic       key_loaded_q;

  cipher u_cipher (
    .key_i  (key_q),
    .data_i (data_q),
    .data_o (cipher_out)
  );

  // A pending key word pre-empts plaintext, so in_ready also looks at key_valid.
  assign bus.key_ready  = (state_q == COLLECT) && (data_cnt_q == 2'd0);
  assign bus.in_ready   = (state_q == COLLECT) && key_loaded_q && (key_cnt_q == 2'd0) && !bus.key_valid;
  assign bus.out_valid  = (state_q == EMIT);
  assign bus.out_word   = (state_q == EMIT) ? col_to_word(out_q, emit_cnt_q) : '0;
  assign bus.busy       = (state_q != COLLECT);
  assign bus.key_loaded = key_loaded_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      key_q        <= '0;
      data_q       <= '0;
      out_q        <= '0;
      key_cnt_q    <= 2'd0;
      data_cnt_q   <= 2'd0;
      emit_cnt_q   <= 2'd0;
      settle_cnt_q <= 4'd0;
      key_loaded_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.key_valid && bus.key_ready) begin
            key_q     <= word_to_col(key_q, key_cnt_q, bus.key_word);
            key_cnt_q <= key_cnt_q + 2'd1;
            if (key_cnt_q == 2'd3) key_loaded_q <= 1'b1;
          end
          if (bus.in_valid && bus.in_ready) begin
            data_q     <= word_to_col(data_q, data_cnt_q, bus.in_word);
            data_cnt_q <= data_cnt_q + 2'd1;
            if (data_cnt_q == 2'd3) begin
              state_q      <= SETTLE;
              settle_cnt_q <= SETTLE_INIT;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt_q == 4'd0) begin
            out_q      <= cipher_out;
            emit_cnt_q <= 2'd0;
            state_q    <= EMIT;
          end else begin
            settle_cnt_q <= settle_cnt_q - 4'd1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            emit_cnt_q <= emit_cnt_q + 2'd1;
            if (emit_cnt_q == 2'd3) begin
              state_q    <= COLLECT;
              data_cnt_q <= 2'd0;
            end
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_stream_loader.sv
// Directed bench for cipher_stream_loader: known AES-128 vectors, gating, backpressure,
// back-to-back timing, asynchronous reset and the settle-window extremes.
module tb_cipher_stream_loader;
  import cipher_stream_loader_pkg::*;

  localparam int S = 2;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // Second block under KEY_B, from the SP 800-38A ECB example.
  localparam logic [127:0] PT_X  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_X  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cipher_stream_loader_if bus ();
  cipher_stream_loader_if bus_s1 ();
  cipher_stream_loader_if bus_s15 ();

  cipher_stream_loader #(.SETTLE_CYCLES(S))  dut     (.clk(clk), .rst(rst), .bus(bus));
  cipher_stream_loader #(.SETTLE_CYCLES(1))  dut_s1  (.clk(clk), .rst(rst), .bus(bus_s1));
  cipher_stream_loader #(.SETTLE_CYCLES(15)) dut_s15 (.clk(clk), .rst(rst), .bus(bus_s15));

  assign bus_s15.key_valid = bus_s1.key_valid;
  assign bus_s15.key_word  = bus_s1.key_word;
  assign bus_s15.in_valid  = bus_s1.in_valid;
  assign bus_s15.in_word   = bus_s1.in_word;
  assign bus_s15.out_ready = bus_s1.out_ready;

  logic  s_vld [2];
  word_t s_dat [2];
  assign s_vld[0] = bus_s1.out_valid;
  assign s_vld[1] = bus_s15.out_valid;
  assign s_dat[0] = bus_s1.out_word;
  assign s_dat[1] = bus_s15.out_word;

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      int n;
      bit hs;
      n = 0;
      hs = 1'b0;
      bus.key_valid = 1'b1;
      bus.key_word  = k[127-32*i -: 32];
      while (!hs && n < 100) begin
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL key_blocks_in_ready: in_ready=%b want 0", bus.in_ready);
        end
        hs = bus.key_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) begin
        errors++;
        $display("FAIL key_hs_timeout: word %0d not accepted", i);
      end
    end
    bus.key_valid = 1'b0;
  endtask

  task automatic send_data(input logic [127:0] d, input int nwords, output int t_last);
    t_last = -1;
    for (int i = 0; i < nwords; i++) begin
      int n;
      bit hs;
      n = 0;
      hs = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_word  = d[127-32*i -: 32];
      while (!hs && n < 200) begin
        @(negedge clk);
        hs = bus.in_ready;
        if (hs) t_last = cyc;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) begin
        errors++;
        $display("FAIL in_hs_timeout: word %0d not accepted", i);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_block(input logic [127:0] exp, input int stall_max, output int t_first);
    t_first = -1;
    for (int i = 0; i < 4; i++) begin
      word_t w;
      int n;
      int st;
      w  = exp[127-32*i -: 32];
      st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
      n  = 0;
      @(negedge clk);
      while (bus.out_valid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (bus.out_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL out_valid_timeout: word %0d never valid", i);
        return;
      end
      if (i == 0) t_first = cyc;
      repeat (st) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== w || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL out_hold w%0d: valid=%b word=%h in_ready=%b want 1/%h/0",
                   i, bus.out_valid, bus.out_word, bus.in_ready, w);
        end
        @(negedge clk);
      end
      checks++;
      if (bus.out_word !== w) begin
        errors++;
        $display("FAIL out_word w%0d: got %h want %h", i, bus.out_word, w);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.key_valid = 1'b0; bus.key_word = '0; bus.in_valid = 1'b0; bus.in_word = '0; bus.out_ready = 1'b0;
    bus_s1.key_valid = 1'b0; bus_s1.key_word = '0; bus_s1.in_valid = 1'b0;
    bus_s1.in_word = '0; bus_s1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL rst_key_loaded: got %b want 0", bus.key_loaded); end
    if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_word !== 32'h0)  begin errors++; $display("FAIL rst_out_word: got %h want 0", bus.out_word); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL rst_key_ready: got %b want 1", bus.key_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_gating();
    int tl;
    int tf;
    bus.in_valid = 1'b1;
    bus.in_word  = PT_B[127:96];
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL gate_no_key: in_ready=%b want 0", bus.in_ready); end
    end
    @(posedge clk); #1;
    fork
      send_key(KEY_B);
      send_data(PT_B, 4, tl);
    join
    checks++;
    if (bus.key_loaded !== 1'b1) begin errors++; $display("FAIL gate_key_loaded: got %b want 1", bus.key_loaded); end
    recv_block(CT_B, 0, tf);
    checks++;
    if (tf - tl != S + 1) begin errors++; $display("FAIL gate_latency: got %0d want %0d", tf - tl, S + 1); end
  endtask

  task automatic test_backpressure();
    int tl;
    int tf;
    send_data(PT_B, 4, tl);
    recv_block(CT_B, 5, tf);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int f1;
    int f2;
    fork
      begin
        send_data(PT_B, 4, t1);
        send_data(PT_X, 4, t2);
      end
      begin
        recv_block(CT_B, 0, f1);
        recv_block(CT_X, 0, f2);
      end
    join
    checks += 2;
    if (f1 - t1 != S + 1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", f1 - t1, S + 1); end
    if (f2 - f1 != 8 + S) begin errors++; $display("FAIL b2b_period: got %0d want %0d", f2 - f1, 8 + S); end
  endtask

  task automatic test_reset_mid();
    int tl;
    int tf;
    int n;
    send_data(PT_B, 2, tl);
    #3 rst = 1'b1;
    #1;
    checks += 6;
    if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL mid_key_loaded: got %b want 0", bus.key_loaded); end
    if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_word !== 32'h0)  begin errors++; $display("FAIL mid_out_word: got %h want 0", bus.out_word); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL mid_key_ready: got %b want 1", bus.key_ready); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    send_key(KEY_B);
    send_data(PT_B, 4, tl);
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL emit_reach: out_valid=%b want 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL emit_rst_out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_word !== 32'h0)  begin errors++; $display("FAIL emit_rst_out_word: got %h want 0", bus.out_word); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL emit_rst_busy: got %b want 0", bus.busy); end
    if (bus.key_loaded !== 1'b0) begin errors++; $display("FAIL emit_rst_key_loaded: got %b want 0", bus.key_loaded); end
    if (bus.key_ready !== 1'b1)  begin errors++; $display("FAIL emit_rst_key_ready: got %b want 1", bus.key_ready); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    send_key(KEY_C);
    send_data(PT_C, 4, tl);
    recv_block(CT_C, 0, tf);
    checks++;
    if (tf - tl != S + 1) begin errors++; $display("FAIL reload_latency: got %0d want %0d", tf - tl, S + 1); end
  endtask

  task automatic watch_settle(input int idx, input int lat, input int tl);
    int n;
    n = 0;
    @(negedge clk);
    while (s_vld[idx] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (cyc - tl != lat) begin errors++; $display("FAIL settle_latency[%0d]: got %0d want %0d", idx, cyc - tl, lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_vld[idx] !== 1'b1 || s_dat[idx] !== CT_C[127-32*i -: 32]) begin
        errors++;
        $display("FAIL settle_word[%0d] w%0d: valid=%b word=%h want %h",
                 idx, i, s_vld[idx], s_dat[idx], CT_C[127-32*i -: 32]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_settle_range();
    int tl;
    tl = -1;
    for (int i = 0; i < 8; i++) begin
      int n;
      bit hs;
      n = 0;
      hs = 1'b0;
      bus_s1.key_valid = (i < 4);
      bus_s1.in_valid  = (i >= 4);
      bus_s1.key_word  = KEY_C[127-32*(i%4) -: 32];
      bus_s1.in_word   = PT_C[127-32*(i%4) -: 32];
      while (!hs && n < 100) begin
        @(negedge clk);
        hs = (i < 4) ? bus_s1.key_ready : bus_s1.in_ready;
        if (hs) tl = cyc;
        @(posedge clk); #1;
        n++;
      end
      if (!hs) begin errors++; $display("FAIL settle_load_timeout: word %0d", i); end
    end
    bus_s1.key_valid = 1'b0;
    bus_s1.in_valid  = 1'b0;
    bus_s1.out_ready = 1'b1;
    fork
      watch_settle(0, 2, tl);
      watch_settle(1, 16, tl);
    join
    bus_s1.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gating();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_settle_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
